// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: pops a burst of words from a FIFO read port and streams them out through a 2-entry skid buffer
module fifo_burst_reader #(
  parameter int DSIZE = 8,
  parameter int CNTW  = 16
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic             start,
  input  logic [CNTW-1:0]  burst_len,
  output logic             busy,
  output logic             done,
  input  logic             rempty,
  input  logic [DSIZE-1:0] rdata,
  output logic             rinc,
  output logic             m_valid,
  output logic [DSIZE-1:0] m_data,
  input  logic             m_ready,
  output logic [CNTW-1:0]  word_cnt,
  output logic [DSIZE-1:0] xsum
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state;
  logic [1:0] occ;
  logic [CNTW-1:0] remaining;
  logic [DSIZE-1:0] skid;
  logic xfer;
  // pop gating is independent of m_ready; a free skid slot is the only backpressure path
  assign rinc = state == RUN && !rempty && remaining != '0 && occ < 2'd2 && !rrst;
  assign m_valid = occ != 2'd0;
  assign xfer = m_valid && m_ready;
  assign busy = state != IDLE;
  always_ff @(posedge rclk) begin
    if (rrst) begin
      state <= IDLE;
      occ <= 2'd0;
      remaining <= '0;
      done <= 1'b0;
      m_data <= '0;
      skid <= '0;
      word_cnt <= '0;
      xsum <= '0;
    end else begin
      done <= 1'b0;
      occ <= occ + 2'(rinc) - 2'(xfer);
      if (xfer && occ == 2'd2) m_data <= skid;
      else if (rinc && (xfer || occ == 2'd0)) m_data <= rdata;
      if (rinc && occ == 2'd1 && !xfer) skid <= rdata;
      if (rinc) remaining <= remaining - 1'b1;
      if (xfer) begin
        word_cnt <= word_cnt + 1'b1;
        xsum <= xsum ^ m_data;
      end
      case (state)
        IDLE:
          if (start) begin
            if (burst_len == '0) done <= 1'b1;
            else begin
              state <= RUN;
              remaining <= burst_len;
              word_cnt <= '0;
              xsum <= '0;
            end
          end
        RUN: if (rinc && remaining == CNTW'(1)) state <= DRAIN;
        DRAIN:
          if (occ == 2'd1 && xfer) begin
            state <= IDLE;
            done <= 1'b1;
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb_fifo_burst_reader: directed and random bursts against a queue-based FIFO and stream scoreboard
module tb_fifo_burst_reader;
  logic rclk = 1'b0, rrst, start, busy, done, rempty, rinc, m_valid, m_ready;
  logic [15:0] burst_len, word_cnt;
  logic [7:0] rdata, m_data, xsum;
  int errors = 0, checks = 0;
  logic [7:0] fq[$];
  logic [7:0] sq[$];
  bit act;
  int m_len, m_pop, m_del, pops_total;
  logic [15:0] e_cnt;
  logic [7:0] e_x;
  int n, sz, p0, wi;
  logic [7:0] words[128];
  logic [7:0] bx[2];

  fifo_burst_reader #(.DSIZE(8), .CNTW(16)) dut (
    .rclk(rclk), .rrst(rrst), .start(start), .burst_len(burst_len), .busy(busy), .done(done),
    .rempty(rempty), .rdata(rdata), .rinc(rinc), .m_valid(m_valid), .m_data(m_data),
    .m_ready(m_ready), .word_cnt(word_cnt), .xsum(xsum)
  );

  always #2 rclk = ~rclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fifo_out();
    rempty = fq.size() == 0;
    rdata = rempty ? 8'h00 : fq[0];
  endtask

  task automatic push(input logic [7:0] w);
    fq.push_back(w);
    fifo_out();
  endtask

  // one rclk cycle: sample pre-edge intent, advance, then update FIFO and stream models
  task automatic step();
    logic p, xv, st, act_pre, e_done;
    logic [7:0] d;
    logic [15:0] bl;
    #1;
    p = rinc;
    xv = m_valid & m_ready;
    d = m_data;
    st = start & !rrst;
    bl = burst_len;
    act_pre = act;
    if (p) chk("no_underflow", rempty, 0);
    @(posedge rclk);
    #1;
    e_done = 1'b0;
    if (rrst) begin
      act = 1'b0;
      sq.delete();
      e_cnt = '0;
      e_x = '0;
      m_pop = 0;
      m_del = 0;
    end else begin
      if (xv) begin
        if (sq.size() == 0) chk("spurious_valid", xv, 0);
        else begin
          chk("stream_order", d, sq.pop_front());
          e_cnt++;
          e_x ^= d;
          m_del++;
          if (act && m_del == m_len) begin
            act = 1'b0;
            e_done = 1'b1;
          end
        end
      end
      if (p) begin
        sq.push_back(fq.pop_front());
        m_pop++;
        pops_total++;
        chk("pop_bound", m_pop <= m_len, 1);
      end
      if (st && !act_pre) begin
        if (bl == 0) e_done = 1'b1;
        else begin
          act = 1'b1;
          m_len = bl;
          m_pop = 0;
          m_del = 0;
          e_cnt = '0;
          e_x = '0;
        end
      end
    end
    fifo_out();
    chk("done", done, e_done);
    chk("busy", busy, act);
    chk("word_cnt", word_cnt, e_cnt);
    chk("xsum", xsum, e_x);
    chk("m_valid", m_valid, sq.size() != 0);
    if (sq.size() != 0) chk("m_data_head", m_data, sq[0]);
  endtask

  task automatic run_until_done(input int budget, output int cnt);
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (!done && cnt < budget);
  endtask

  initial begin
    rrst = 1'b1; start = 1'b0; burst_len = '0; m_ready = 1'b0;
    act = 1'b0; m_len = 0; m_pop = 0; m_del = 0; pops_total = 0; e_cnt = '0; e_x = '0;
    fifo_out();
    step();
    step();
    rrst = 1'b0;
    chk("rst_m_data", m_data, 0);
    chk("rst_done", done, 0);

    // basic burst at full throughput
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    p0 = pops_total;
    m_ready = 1'b1; start = 1'b1; burst_len = 16'd4;
    step();
    start = 1'b0;
    run_until_done(50, n);
    chk("t2_cycles", n, 5);
    chk("t2_word_cnt", word_cnt, 4);
    chk("t2_xsum", xsum, 8'h44);
    chk("t2_pops", pops_total - p0, 4);
    step();
    chk("t2_done_one_cycle", done, 0);
    chk("t2_idle", busy, 0);

    // backpressure saturates the skid buffer
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    m_ready = 1'b0; start = 1'b1; burst_len = 16'd4;
    step();
    start = 1'b0;
    repeat (5) step();
    #1;
    chk("t3_rinc_stalled", rinc, 0);
    chk("t3_hold_data", m_data, 8'h11);
    chk("t3_fifo_left", fq.size(), 2);
    m_ready = 1'b1;
    run_until_done(50, n);
    chk("t3_done", done, 1);
    chk("t3_word_cnt", word_cnt, 4);
    chk("t3_xsum", xsum, 8'h44);

    // empty FIFO stalls popping, burst waits
    push(8'hA5);
    start = 1'b1; burst_len = 16'd3;
    step();
    start = 1'b0;
    repeat (20) step();
    #1;
    chk("t4_busy", busy, 1);
    chk("t4_rinc_empty", rinc, 0);
    chk("t4_word_cnt", word_cnt, 1);
    push(8'h3C); push(8'h0F);
    run_until_done(50, n);
    chk("t4_done", done, 1);
    chk("t4_xsum", xsum, 8'hA5 ^ 8'h3C ^ 8'h0F);

    // zero length, then start ignored while running
    p0 = pops_total;
    start = 1'b1; burst_len = 16'd0;
    step();
    start = 1'b0;
    chk("t5_zero_done", done, 1);
    chk("t5_zero_pops", pops_total - p0, 0);
    push(8'h01); push(8'h02); push(8'h04); push(8'h08); push(8'h10);
    start = 1'b1; burst_len = 16'd3;
    step();
    burst_len = 16'd7;
    step();
    step();
    start = 1'b0;
    run_until_done(50, n);
    chk("t5_len_kept", word_cnt, 3);
    chk("t5_xsum", xsum, 8'h07);
    chk("t5_fifo_left", fq.size(), 2);
    fq.delete();
    fifo_out();

    // reset mid-burst with a full skid buffer
    push(8'hC1); push(8'hC2); push(8'hC3); push(8'hC4);
    m_ready = 1'b0; start = 1'b1; burst_len = 16'd4;
    step();
    start = 1'b0;
    step();
    step();
    sz = fq.size();
    rrst = 1'b1;
    step();
    rrst = 1'b0;
    chk("t1_m_valid", m_valid, 0);
    chk("t1_busy", busy, 0);
    chk("t1_no_pop", fq.size(), sz);
    start = 1'b1; burst_len = 16'd2;
    step();
    start = 1'b0;
    rrst = 1'b1;
    #1;
    chk("t1_rinc_forced", rinc, 0);
    step();
    rrst = 1'b0;
    chk("t1_no_pop_run", fq.size(), sz);
    fq.delete();
    fifo_out();
    step();

    // random writer and sink, two bursts of 64
    bx[0] = '0; bx[1] = '0;
    for (int i = 0; i < 128; i++) begin
      words[i] = 8'($urandom);
      bx[i / 64] ^= words[i];
    end
    wi = 0;
    for (int b = 0; b < 2; b++) begin
      start = 1'b1; burst_len = 16'd64; m_ready = 1'($urandom_range(0, 1));
      step();
      start = 1'b0;
      n = 0;
      while (!done && n < 3000) begin
        if (wi < 128 && $urandom_range(0, 1) == 1) begin
          push(words[wi]);
          wi++;
        end
        m_ready = 1'($urandom_range(0, 1));
        step();
        n++;
      end
      chk("t6_done", done, 1);
      chk("t6_word_cnt", word_cnt, 64);
      chk("t6_xsum", xsum, bx[b]);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
